// File: rtl/rng_pkg.sv
// rng_pkg: shared types, default constants and the Galois step helper
// for the rng_lfsr random number generator.
//   rng_state_t      - FSM encoding (IDLE accepts requests, GEN steps)
//   DEFAULT_TAPS_16  - maximal-length 16-bit Galois feedback mask
//   DEFAULT_SEED_16  - non-zero reset seed
//   galois_step()    - one right-shifting Galois step on a zero-extended word
package rng_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        GEN  = 1'b1
    } rng_state_t;

    localparam logic [15:0] DEFAULT_TAPS_16 = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED_16 = 16'hACE1;

    // galois_step works on a fixed wide word so that any LFSR width up to
    // RNG_MAX_W-1 can share it; callers zero-extend and slice the result.
    localparam int RNG_MAX_W = 64;

    function automatic logic [RNG_MAX_W-1:0] galois_step(
        input logic [RNG_MAX_W-1:0] lfsr,
        input logic [RNG_MAX_W-1:0] taps
    );
        return (lfsr >> 1) ^ (lfsr[0] ? taps : '0);
    endfunction

endpackage

// File: rtl/rng_lfsr_if.sv
// rng_lfsr_if: request/result handshake between a requester and rng_lfsr.
//   req       - requester asks for DATA_OUT_WIDTH fresh bits
//   ready     - generator is idle and will accept req at this clock edge
//   out_valid - one-cycle pulse, out carries a new value
//   out       - result, held stable until the next out_valid
// Handshake: a request is accepted at a rising edge where req and ready are
// both high; req while ready is low is simply ignored (not queued), so the
// requester holds or reissues it. out_valid is a pulse, not a valid/ready
// pair: the result is not back-pressured and the consumer must take it.
interface rng_lfsr_if #(
    parameter int DATA_OUT_WIDTH = 2
);
    logic                      req;
    logic                      ready;
    logic                      out_valid;
    logic [DATA_OUT_WIDTH-1:0] out;

    modport master (
        output req,
        input  ready,
        input  out_valid,
        input  out
    );

    modport slave (
        input  req,
        output ready,
        output out_valid,
        output out
    );
endinterface

// File: rtl/rng_lfsr_core.sv
// lfsr_core: Galois LFSR register with load, step and zero guard.
//   clk, rst   - clock, synchronous active-high reset (loads DEFAULT_SEED)
//   step_en    - advance one Galois step this cycle
//   load_en    - load load_val this cycle (wins over step_en)
//   load_val   - value to load
//   lfsr       - current register contents (never zero)
//   next_bits  - low OUT_WIDTH bits of the stepped value
module lfsr_core
    import rng_pkg::*;
#(
    parameter int                    LFSR_WIDTH   = 16,
    parameter int                    OUT_WIDTH    = 2,
    parameter logic [LFSR_WIDTH-1:0] TAPS         = LFSR_WIDTH'(DEFAULT_TAPS_16),
    parameter logic [LFSR_WIDTH-1:0] DEFAULT_SEED = LFSR_WIDTH'(DEFAULT_SEED_16)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  step_en,
    input  logic                  load_en,
    input  logic [LFSR_WIDTH-1:0] load_val,
    output logic [LFSR_WIDTH-1:0] lfsr,
    output logic [OUT_WIDTH-1:0]  next_bits
);

    logic [RNG_MAX_W-1:0]            wide_next;
    logic [RNG_MAX_W-LFSR_WIDTH-1:0] unused_hi;
    logic [LFSR_WIDTH-1:0]           lfsr_next;
    logic [LFSR_WIDTH-1:0]           lfsr_d;
    logic [LFSR_WIDTH-1:0]           lfsr_q;

    assign wide_next              = galois_step(RNG_MAX_W'(lfsr_q), RNG_MAX_W'(TAPS));
    assign {unused_hi, lfsr_next} = wide_next;

    // The guard sits after the mux so every path into the register (seed
    // load, entropy fold, step) is covered by the same single check.
    always_comb begin
        lfsr_d = lfsr_q;
        if (load_en) begin
            lfsr_d = load_val;
        end else if (step_en) begin
            lfsr_d = lfsr_next;
        end
        if (lfsr_d == '0) begin
            lfsr_d = DEFAULT_SEED;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= DEFAULT_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr      = lfsr_q;
    assign next_bits = lfsr_next[OUT_WIDTH-1:0];

endmodule

// File: rtl/rng_lfsr.sv
// rng_lfsr: on-demand pseudo-random generator for the Genius game core.
// Each accepted request steps the Galois LFSR DATA_OUT_WIDTH times and
// returns the low bits of the final value. A free-running entropy counter
// can be XOR-folded into the LFSR on a user event; load_seed reseeds it.
//   clk, rst     - clock, synchronous active-high reset
//   seed         - explicit seed (zero is replaced by DEFAULT_SEED)
//   load_seed    - load seed now; aborts an in-flight generation
//   entropy_evt  - fold the entropy counter into the LFSR (IDLE only)
//   bus          - req/ready/out_valid/out handshake (slave side)
//   dbg_state    - FSM state register
//   dbg_lfsr     - LFSR register contents
module rng_lfsr
    import rng_pkg::*;
#(
    parameter int                    LFSR_WIDTH     = 16,
    parameter int                    DATA_OUT_WIDTH = 2,
    parameter logic [LFSR_WIDTH-1:0] TAPS           = LFSR_WIDTH'(DEFAULT_TAPS_16),
    parameter logic [LFSR_WIDTH-1:0] DEFAULT_SEED   = LFSR_WIDTH'(DEFAULT_SEED_16)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [LFSR_WIDTH-1:0] seed,
    input  logic                  load_seed,
    input  logic                  entropy_evt,
    rng_lfsr_if.slave             bus,
    output rng_state_t            dbg_state,
    output logic [LFSR_WIDTH-1:0] dbg_lfsr
);

    if (LFSR_WIDTH < 3 || LFSR_WIDTH >= RNG_MAX_W) begin : g_bad_width
        $error("rng_lfsr: LFSR_WIDTH out of range");
    end
    if (DATA_OUT_WIDTH < 1 || DATA_OUT_WIDTH > LFSR_WIDTH) begin : g_bad_out
        $error("rng_lfsr: DATA_OUT_WIDTH must be 1..LFSR_WIDTH");
    end
    if (TAPS[LFSR_WIDTH-1] != 1'b1) begin : g_bad_taps
        $error("rng_lfsr: TAPS must have its top bit set");
    end
    if (DEFAULT_SEED == '0) begin : g_bad_seed
        $error("rng_lfsr: DEFAULT_SEED must be non-zero");
    end

    localparam int STEP_W = (DATA_OUT_WIDTH > 1) ? $clog2(DATA_OUT_WIDTH) : 1;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(DATA_OUT_WIDTH - 1);

    rng_state_t                state_q, state_d;
    logic [STEP_W-1:0]         step_q, step_d;
    logic [LFSR_WIDTH-1:0]     ent_cnt_q;
    logic [DATA_OUT_WIDTH-1:0] out_q, out_d;
    logic                      valid_q, valid_d;

    logic                      step_en;
    logic                      load_en;
    logic [LFSR_WIDTH-1:0]     load_val;
    logic [LFSR_WIDTH-1:0]     lfsr;
    logic [DATA_OUT_WIDTH-1:0] next_bits;

    lfsr_core #(
        .LFSR_WIDTH   (LFSR_WIDTH),
        .OUT_WIDTH    (DATA_OUT_WIDTH),
        .TAPS         (TAPS),
        .DEFAULT_SEED (DEFAULT_SEED)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .step_en   (step_en),
        .load_en   (load_en),
        .load_val  (load_val),
        .lfsr      (lfsr),
        .next_bits (next_bits)
    );

    // State register, step counter, entropy counter and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            step_q    <= '0;
            ent_cnt_q <= '0;
            out_q     <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            ent_cnt_q <= ent_cnt_q + 1'b1;
            out_q     <= out_d;
            valid_q   <= valid_d;
        end
    end

    // Next state. load_seed beats everything; entropy beats req in IDLE.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        if (load_seed) begin
            state_d = IDLE;
            step_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!entropy_evt && bus.req) begin
                        state_d = GEN;
                        step_d  = '0;
                    end
                end
                GEN: begin
                    if (step_q == LAST_STEP) begin
                        state_d = IDLE;
                        step_d  = '0;
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    step_d  = '0;
                end
            endcase
        end
    end

    // Datapath controls and output register inputs.
    always_comb begin
        step_en  = 1'b0;
        load_en  = 1'b0;
        load_val = seed;
        out_d    = out_q;
        valid_d  = 1'b0;
        if (load_seed) begin
            load_en  = 1'b1;
            load_val = seed;
        end else if (state_q == IDLE) begin
            if (entropy_evt) begin
                load_en  = 1'b1;
                load_val = lfsr ^ ent_cnt_q;
            end
        end else begin
            step_en = 1'b1;
            if (step_q == LAST_STEP) begin
                out_d   = next_bits;
                valid_d = 1'b1;
            end
        end
    end

    assign bus.ready     = (state_q == IDLE);
    assign bus.out_valid = valid_q;
    assign bus.out       = out_q;
    assign dbg_state     = state_q;
    assign dbg_lfsr      = lfsr;

endmodule

// File: tb/tb_rng_lfsr.sv
// tb_rng_lfsr: directed bench for rng_lfsr. A cycle-level behavioural model
// of the generator is compared with the main DUT on every falling edge; a
// second DUT with DATA_OUT_WIDTH=4 is checked per result over a long run.
module tb_rng_lfsr;
    import rng_pkg::*;

    localparam int          W    = 16;
    localparam int          DOW  = 2;
    localparam int          DOW4 = 4;
    localparam logic [15:0] SEED0 = 16'hACE1;
    localparam logic [15:0] TAPS0 = 16'hB400;
    localparam int          N4   = 2500;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [W-1:0] seed        = '0;
    logic         load_seed   = 1'b0;
    logic         entropy_evt = 1'b0;

    rng_lfsr_if #(.DATA_OUT_WIDTH(DOW))  bus ();
    rng_lfsr_if #(.DATA_OUT_WIDTH(DOW4)) bus4 ();

    rng_state_t   dbg_state, dbg_state4;
    logic [W-1:0] dbg_lfsr, dbg_lfsr4;

    rng_lfsr #(.LFSR_WIDTH(W), .DATA_OUT_WIDTH(DOW)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .seed        (seed),
        .load_seed   (load_seed),
        .entropy_evt (entropy_evt),
        .bus         (bus),
        .dbg_state   (dbg_state),
        .dbg_lfsr    (dbg_lfsr)
    );

    rng_lfsr #(.LFSR_WIDTH(W), .DATA_OUT_WIDTH(DOW4)) u_dut4 (
        .clk         (clk),
        .rst         (rst),
        .seed        ('0),
        .load_seed   (1'b0),
        .entropy_evt (1'b0),
        .bus         (bus4),
        .dbg_state   (dbg_state4),
        .dbg_lfsr    (dbg_lfsr4)
    );

    // ---------------- scoreboard counters ----------------
    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] gstep(input logic [W-1:0] x);
        return x[0] ? ((x >> 1) ^ TAPS0) : (x >> 1);
    endfunction

    // ---------------- behavioural model (main DUT) ----------------
    // m_rem counts the steps still owed to an accepted request; 0 = idle.
    logic [W-1:0]   m_lfsr  = SEED0;
    logic [W-1:0]   m_ent   = '0;
    logic [W-1:0]   m_x;
    int             m_rem   = 0;
    logic [DOW-1:0] m_out   = '0;
    logic           m_valid = 1'b0;
    logic           checking = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_lfsr  = SEED0;
            m_ent   = '0;
            m_rem   = 0;
            m_out   = '0;
            m_valid = 1'b0;
        end else begin
            m_valid = 1'b0;
            if (load_seed) begin
                m_lfsr = (seed == '0) ? SEED0 : seed;
                m_rem  = 0;
            end else if (m_rem == 0) begin
                if (entropy_evt) begin
                    m_x    = m_lfsr ^ m_ent;
                    m_lfsr = (m_x == '0) ? SEED0 : m_x;
                end else if (bus.req) begin
                    m_rem = DOW;
                end
            end else begin
                m_lfsr = gstep(m_lfsr);
                m_rem  = m_rem - 1;
                if (m_rem == 0) begin
                    m_out   = m_lfsr[DOW-1:0];
                    m_valid = 1'b1;
                end
            end
            m_ent = m_ent + 1'b1;
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            chk("ready",     32'(bus.ready),     32'(m_rem == 0));
            chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
            chk("out",       32'(bus.out),       32'(m_out));
            chk("lfsr",      32'(dbg_lfsr),      32'(m_lfsr));
            chk("state",     32'(dbg_state),     (m_rem == 0) ? 32'(IDLE) : 32'(GEN));
        end
    end

    // ---------------- long-run model (DATA_OUT_WIDTH=4 DUT) ----------------
    logic [W-1:0] m4_lfsr    = SEED0;
    int           m4_steps   = 0;
    int           m4_results = 0;
    logic         run4       = 1'b0;

    always @(negedge clk) begin
        if (run4) begin
            chk("lfsr4_nonzero", 32'(dbg_lfsr4 != '0), 32'd1);
            if (bus4.out_valid) begin
                for (int i = 0; i < DOW4; i++) m4_lfsr = gstep(m4_lfsr);
                m4_steps   += DOW4;
                m4_results += 1;
                chk("out4",  32'(bus4.out), 32'(m4_lfsr[DOW4-1:0]));
                chk("lfsr4", 32'(dbg_lfsr4), 32'(m4_lfsr));
                if (m4_steps < 65535) chk("lfsr4_no_early_return", 32'(dbg_lfsr4 != SEED0), 32'd1);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic do_load(input logic [W-1:0] s);
        seed      = s;
        load_seed = 1'b1;
        tick();
        load_seed = 1'b0;
    endtask

    // One-cycle req, then wait until the out_valid cycle (c+DOW+1).
    task automatic do_req_wait();
        bus.req = 1'b1;
        tick();
        bus.req = 1'b0;
        repeat (DOW) tick();
    endtask

    logic [15:0] seed_tab [4] = '{16'hBEEF, 16'h8000, 16'hFFFF, 16'h0002};
    logic [W-1:0] e_snap;

    // ---------------- stimulus ----------------
    initial begin
        bus.req  = 1'b0;
        bus4.req = 1'b0;
        do_reset();
        checking = 1'b1;

        // Reset values
        chk("rst_ready", 32'(bus.ready), 32'd1);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out",   32'(bus.out), 32'd0);
        chk("rst_lfsr",  32'(dbg_lfsr), 32'hACE1);

        // First request: ACE1 -> E270 -> 7138, out 00
        bus.req = 1'b1;
        tick();
        bus.req = 1'b0;
        chk("req1_busy_a", 32'(bus.ready), 32'd0);
        tick();
        chk("req1_busy_b", 32'(bus.ready), 32'd0);
        tick();
        chk("req1_valid", 32'(bus.out_valid), 32'd1);
        chk("req1_ready", 32'(bus.ready), 32'd1);
        chk("req1_lfsr",  32'(dbg_lfsr), 32'h7138);
        chk("req1_out",   32'(bus.out), 32'd0);

        // Back-to-back request on the out_valid cycle: 7138 -> 389C -> 1C4E
        bus.req = 1'b1;
        tick();
        bus.req = 1'b0;
        chk("req2_busy_a", 32'(bus.ready), 32'd0);
        tick();
        chk("req2_busy_b", 32'(bus.ready), 32'd0);
        tick();
        chk("req2_valid", 32'(bus.out_valid), 32'd1);
        chk("req2_ready", 32'(bus.ready), 32'd1);
        chk("req2_lfsr",  32'(dbg_lfsr), 32'h1C4E);
        chk("req2_out",   32'(bus.out), 32'd2);
        tick();
        chk("req2_pulse", 32'(bus.out_valid), 32'd0);

        // Zero seed is replaced by the default seed
        do_load('0);
        chk("seed0_lfsr", 32'(dbg_lfsr), 32'hACE1);

        // Seed 1: 0001 -> B400 -> 5A00, out 00
        do_load(16'h0001);
        do_req_wait();
        chk("seed1_valid", 32'(bus.out_valid), 32'd1);
        chk("seed1_lfsr",  32'(dbg_lfsr), 32'h5A00);
        chk("seed1_out",   32'(bus.out), 32'd0);

        // Entropy fold giving zero: seed equals the counter value at the fold
        do_load(m_ent + 16'd1);
        entropy_evt = 1'b1;
        tick();
        entropy_evt = 1'b0;
        chk("ent_zero_lfsr", 32'(dbg_lfsr), 32'hACE1);

        // Entropy together with req: req dropped
        e_snap      = m_ent;
        entropy_evt = 1'b1;
        bus.req     = 1'b1;
        tick();
        entropy_evt = 1'b0;
        bus.req     = 1'b0;
        chk("ent_req_ready", 32'(bus.ready), 32'd1);
        chk("ent_req_lfsr",  32'(dbg_lfsr), 32'(16'hACE1 ^ e_snap));
        repeat (3) tick();
        chk("ent_req_novalid", 32'(bus.out_valid), 32'd0);

        // Abort with load_seed in the first GEN cycle
        do_load(16'h7138);
        do_req_wait();
        chk("pre_abort_out", 32'(bus.out), 32'd2);
        bus.req = 1'b1;
        tick();
        bus.req   = 1'b0;
        seed      = 16'h1234;
        load_seed = 1'b1;
        tick();
        load_seed = 1'b0;
        chk("abort_ready", 32'(bus.ready), 32'd1);
        chk("abort_valid", 32'(bus.out_valid), 32'd0);
        chk("abort_out",   32'(bus.out), 32'd2);
        chk("abort_lfsr",  32'(dbg_lfsr), 32'h1234);
        tick();
        tick();
        chk("abort_novalid", 32'(bus.out_valid), 32'd0);

        // Reset in the middle of GEN
        bus.req = 1'b1;
        tick();
        bus.req = 1'b0;
        rst     = 1'b1;
        tick();
        rst     = 1'b0;
        chk("midrst_ready", 32'(bus.ready), 32'd1);
        chk("midrst_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_out",   32'(bus.out), 32'd0);
        chk("midrst_lfsr",  32'(dbg_lfsr), 32'hACE1);

        // Held req over a few seeds (model-checked every cycle)
        for (int k = 0; k < 4; k++) begin
            do_load(seed_tab[k]);
            bus.req = 1'b1;
            repeat (3 * (DOW + 1)) tick();
            bus.req = 1'b0;
            repeat (DOW + 2) tick();
        end

        // Long run on the 4-bit instance from the reset seed
        do_reset();
        m4_lfsr    = SEED0;
        m4_steps   = 0;
        m4_results = 0;
        run4       = 1'b1;
        bus4.req   = 1'b1;
        repeat (N4 * (DOW4 + 1) + 2) tick();
        bus4.req = 1'b0;
        run4     = 1'b0;
        chk("results4", 32'(m4_results >= N4), 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/rng_lfsr.md
# rng_lfsr

Parametrised pseudo-random number generator for the Genius game core. It supplies the colour/step index for each new round of the sequence. A Galois LFSR of configurable width and tap mask is advanced on demand through a req/ready/valid handshake, producing DATA_OUT_WIDTH fresh bits per request. Seeding is explicit via load_seed or by folding a free-running entropy counter into the LFSR on a user event such as a button press. A zero-state guard makes lock-up impossible.

## Interface
- LFSR_WIDTH, 16, LFSR register width (≥ 3).
- DATA_OUT_WIDTH, 2, bits delivered per request (1 ≤ DATA_OUT_WIDTH ≤ LFSR_WIDTH).
- TAPS, 16'hB400, Galois feedback mask, LFSR_WIDTH bits; bit LFSR_WIDTH-1 must be 1.
- DEFAULT_SEED, 16'hACE1, reset value and zero-guard replacement; must be non-zero.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- seed  in  LFSR_WIDTH  explicit seed value.
- load_seed  in  1  load seed into the LFSR this cycle.
- entropy_evt  in  1  single-cycle user event; XOR-folds the entropy counter into the LFSR.
- req  in  1  request DATA_OUT_WIDTH new bits.
- ready  out  1  high when a request can be accepted (state IDLE).
- out_valid  out  1  one-cycle pulse: out holds a new value.
- out  out  DATA_OUT_WIDTH  random value; held stable until the next out_valid.

## Operation
- Galois step: lfsr ← (lfsr >> 1) ^ (lfsr[0] ? TAPS : 0).
- ent_cnt is a LFSR_WIDTH-bit counter that increments every cycle, wraps modulo 2^LFSR_WIDTH, and is cleared only by rst.
- FSM states:
  - IDLE (ready = 1).
  - GEN (ready = 0, step counter 0..DATA_OUT_WIDTH-1).
- Transitions, in priority order per cycle:
  - rst: lfsr ← DEFAULT_SEED, ent_cnt ← 0, state IDLE, step counter 0, out ← 0, out_valid ← 0.
  - load_seed (any state): lfsr ← seed, or DEFAULT_SEED if seed == 0. State ← IDLE, no out_valid; an in-flight GEN is aborted and out keeps its old value.
  - IDLE & entropy_evt: lfsr ← lfsr ^ ent_cnt, or DEFAULT_SEED if the result is 0. If req is also high the same cycle, entropy wins and req is not accepted.
  - IDLE & req: state ← GEN, step counter ← 0; lfsr unchanged this cycle.
  - GEN: lfsr steps once per cycle and the step counter increments. On the DATA_OUT_WIDTH-th step, state ← IDLE, out ← lfsr_next[DATA_OUT_WIDTH-1:0], out_valid ← 1.
- entropy_evt in GEN is ignored (not queued).
- lfsr holds its value in IDLE with no events; it advances only in GEN.
- The zero guard applies to every load path, so lfsr is never 0 after any edge.

## Timing
- A req sampled high with ready at the end of cycle c gives:
  - ready = 0 in cycles c+1 … c+DATA_OUT_WIDTH.
  - out_valid = 1 and ready = 1 in cycle c+DATA_OUT_WIDTH+1.
- A new req may be accepted in the same cycle out_valid is high; back-to-back throughput is one result per DATA_OUT_WIDTH+1 cycles.
- req while ready = 0 is ignored; the requester must hold or reissue it.
- ready is decoded directly from the state register (no input-to-output combinational path). out and out_valid are registered.
- Reset values: ready = 1, out_valid = 0, out = 0.

## Structure
- Package rng_pkg holds:
  - typedef enum logic {IDLE, GEN} rng_state_t;
  - localparam DEFAULT_TAPS_16 = 16'hB400 and DEFAULT_SEED_16 = 16'hACE1.
  - A function galois_step(lfsr, taps).
- Sub-module lfsr_core: LFSR register, step, load, and zero guard, driven by step_en, load_en, load_val. The rng_lfsr top holds the FSM, ent_cnt, and output registers.
- Elaboration-time assertions check the parameter constraints above.

## Test plan
- Reset, then req for one cycle (defaults): out_valid 3 cycles after the req cycle; lfsr goes 0xACE1→0xE270→0x7138; out = 2'b00.
- Second req immediately on the out_valid cycle: lfsr 0x7138→0x389C→0x1C4E; out = 2'b10. Check ready is low for exactly 2 cycles.
- load_seed with seed = 0: lfsr = 0xACE1. load_seed with seed = 0x0001 followed by req: 0x0001→0xB400→0x5A00, out = 2'b00.
- Drive entropy_evt in IDLE when ent_cnt = lfsr: the XOR gives 0, so lfsr = 0xACE1. Also assert entropy_evt together with req: req is dropped and ready stays 1.
- Abort: load_seed asserted in the 1st GEN cycle gives no out_valid, state IDLE next cycle, and out unchanged. Repeat with rst mid-GEN: all outputs return to reset values.
- With DATA_OUT_WIDTH=4, LFSR_WIDTH=16, run 65535 requests × 4 steps from 0xACE1: lfsr returns to 0xACE1 only after 65535 steps (maximal period) and is never 0.
